// File: rtl/rr_mux4_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin burst arbiter.
package rr_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {IDLE, BUSY} arb_state_t;

    // Priority rotation: the requester after idx becomes the new head, wrapping 3 -> 0.
    function automatic logic [SEL_W-1:0] rr_next(input logic [SEL_W-1:0] idx);
        return idx + SEL_W'(1);
    endfunction
endpackage

// File: rtl/rr_mux4_arbiter_if.sv
// Requester-side and consumer-side valid/ready channels of the arbiter.
interface rr_mux4_arbiter_if import rr_arb_pkg::*; #(
    parameter int WIDTH = 8
);
    logic [NUM_REQ-1:0]       in_valid;
    logic [NUM_REQ*WIDTH-1:0] in_data;
    logic [NUM_REQ-1:0]       in_last;
    logic [NUM_REQ-1:0]       in_ready;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_last;
    logic [SEL_W-1:0]         out_src;
    logic                     out_ready;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_data, out_last, out_src
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_data, out_last, out_src
    );
endinterface

// File: rtl/rr_mux4_arbiter_pick4.sv
// Combinational rotating-priority picker: first set req bit searching ptr, ptr+1, ... mod 4.
module rr_pick4 import rr_arb_pkg::*; (
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   ptr,
    output logic [SEL_W-1:0]   idx,
    output logic               found
);
    logic [SEL_W-1:0] cand;

    // Walk from lowest to highest priority so the last hit (k = 0) wins.
    always_comb begin
        idx   = '0;
        found = 1'b0;
        cand  = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + SEL_W'(k);
            if (req[cand]) begin
                idx   = cand;
                found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/rr_mux4_arbiter.sv
// Round-robin burst arbiter: locks a 4:1 mux onto one requester per burst, then rotates priority.
module rr_mux4_arbiter import rr_arb_pkg::*; #(
    parameter int WIDTH     = 8,
    parameter int MAX_BURST = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    rr_mux4_arbiter_if.master  bus,
    output logic [SEL_W-1:0]   sel,
    output logic [NUM_REQ-1:0] grant,
    output logic               busy
);
    localparam int CNT_W = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);

    arb_state_t         state, state_nxt;
    logic [SEL_W-1:0]   ptr, ptr_nxt, sel_nxt, pick_idx;
    logic [NUM_REQ-1:0] grant_nxt;
    logic [CNT_W-1:0]   beat_cnt, cnt_nxt;
    logic               pick_found, xfer;
    logic [WIDTH-1:0]   lane [NUM_REQ];

    rr_pick4 u_pick (
        .req   (bus.in_valid),
        .ptr   (ptr),
        .idx   (pick_idx),
        .found (pick_found)
    );

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = bus.in_data[i*WIDTH +: WIDTH];
    end

    assign busy         = (state == BUSY);
    assign bus.out_src  = sel;
    assign bus.out_data = lane[sel];
    assign xfer         = bus.out_valid & bus.out_ready;

    // Output channel is a pure mux of the owner while BUSY; everything quiet in IDLE.
    always_comb begin
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.in_ready  = '0;
        if (busy) begin
            bus.out_valid     = bus.in_valid[sel];
            bus.out_last      = bus.in_last[sel] | (beat_cnt == LAST_CNT);
            bus.in_ready[sel] = bus.out_ready;
        end
    end

    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        sel_nxt   = sel;
        grant_nxt = grant;
        cnt_nxt   = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_nxt = BUSY;
                    sel_nxt   = pick_idx;
                    grant_nxt = NUM_REQ'(1) << pick_idx;
                    cnt_nxt   = '0;
                end
            end
            BUSY: begin
                if (xfer) begin
                    if (bus.out_last) begin
                        // Owner drops to lowest priority; a mandatory IDLE cycle follows.
                        state_nxt = IDLE;
                        ptr_nxt   = rr_next(sel);
                        grant_nxt = '0;
                        cnt_nxt   = '0;
                    end else begin
                        cnt_nxt = beat_cnt + CNT_W'(1);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            ptr      <= '0;
            sel      <= '0;
            grant    <= '0;
            beat_cnt <= '0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            sel      <= sel_nxt;
            grant    <= grant_nxt;
            beat_cnt <= cnt_nxt;
        end
    end
endmodule
